// File: rtl/frag_writer_pkg.sv
// frag_writer_pkg: shared types and defaults for the fragment writer.
//   fragment_t  - one fragment as delivered by the generator FIFO
//   wq_entry_t  - one pending framebuffer write {addr, data}
//   state_e     - writer control FSM states
// Optional build macro used by frag_writer: FRAG_WRITER_STATS_EN.
package frag_writer_pkg;

    localparam int unsigned FbWidthDefault  = 640;
    localparam int unsigned FbHeightDefault = 480;
    localparam int unsigned LgWqSzDefault   = 2;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
    } fragment_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wq_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // fp32 sign test; -0.0 counts as non-negative, NaN is not special-cased.
    function automatic logic w_nonneg(input logic [31:0] w);
        return !w[31] || (w[30:0] == 31'd0);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/frag_write_queue.sv
// frag_write_queue: circular push/pop FIFO of pending framebuffer writes.
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i/push_data_i  enqueue; accepted when not full, or when full and popping
//   pop_i/pop_data_o    dequeue head / current head entry
//   full_o, empty_o, count_o  status; count_o is the occupancy (0..2^LgDepth)
module frag_write_queue #(
    parameter int unsigned LgDepth = 2,
    parameter int unsigned Width   = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [Width-1:0]   push_data_i,
    input  logic               pop_i,
    output logic [Width-1:0]   pop_data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [LgDepth:0]   count_o
);

    localparam int unsigned Depth = 1 << LgDepth;

    logic [Width-1:0] mem_q [Depth];
    logic [LgDepth:0] wr_ptr_q, wr_ptr_d;
    logic [LgDepth:0] rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[LgDepth-1:0] == rd_ptr_q[LgDepth-1:0]) &&
                     (wr_ptr_q[LgDepth] != rd_ptr_q[LgDepth]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign pop_data_o = mem_q[rd_ptr_q[LgDepth-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[LgDepth-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/frag_writer.sv
// frag_writer: consumes fragments from the generator FIFO, keeps those inside the
// triangle and the framebuffer, and issues one 32-bit colour write per kept pixel.
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, fb_base_i, color_i  begin a triangle (IDLE only); base/colour latched
//   gen_done_i              generator finished (pulse, latched)
//   frag_val_i, *_in_i, pop_frag_o  generator FIFO head and dequeue strobe
//   mem_req_*               valid/ready write port (byte address, data)
//   done_o                  one-cycle pulse when all writes have drained
//   stat_*_o                pop/cull/write counters, built only with FRAG_WRITER_STATS_EN
module frag_writer
    import frag_writer_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = FbWidthDefault,
    parameter int unsigned FB_HEIGHT = FbHeightDefault,
    parameter int unsigned LG_WQ_SZ  = LgWqSzDefault
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] fb_base_i,
    input  logic [31:0] color_i,
    input  logic        gen_done_i,
    input  logic        frag_val_i,
    input  logic [31:0] x_in_i,
    input  logic [31:0] y_in_i,
    input  logic [31:0] w0_in_i,
    input  logic [31:0] w1_in_i,
    input  logic [31:0] w2_in_i,
    output logic        pop_frag_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    output logic [31:0] mem_req_data_o,
    output logic        done_o,
    output logic [31:0] stat_in_o,
    output logic [31:0] stat_culled_o,
    output logic [31:0] stat_written_o
);

    localparam int unsigned WqDepth = 1 << LG_WQ_SZ;

    state_e      state_q, state_d;
    logic        gen_done_seen_q, gen_done_seen_d;
    logic [31:0] fb_base_q, fb_base_d;
    logic [31:0] color_q, color_d;
    fragment_t   stage_q, frag_in;
    logic        stage_valid_q;

    logic              start_acc;
    logic              keep;
    logic [31:0]       pix_idx;
    wq_entry_t         push_entry, head_entry;
    logic              q_push, q_full, q_empty;
    logic [LG_WQ_SZ:0] q_count;
    logic [LG_WQ_SZ+1:0] occ;
    logic              xfer;

    assign frag_in   = {x_in_i, y_in_i, w0_in_i, w1_in_i, w2_in_i};
    assign start_acc = (state_q == StIdle) && start_i;

    // Reserve a queue slot for the fragment in the stage so a push never stalls.
    assign occ = {1'b0, q_count} + {{(LG_WQ_SZ + 1){1'b0}}, stage_valid_q};
    assign pop_frag_o = (state_q == StRun) && frag_val_i && !q_full &&
                        (occ < (LG_WQ_SZ + 2)'(WqDepth));

    // Stage evaluation: coverage, bounds and address, all in one cycle.
    assign keep = w_nonneg(stage_q.w0) && w_nonneg(stage_q.w1) && w_nonneg(stage_q.w2) &&
                  (stage_q.x < 32'(FB_WIDTH)) && (stage_q.y < 32'(FB_HEIGHT));
    assign pix_idx         = stage_q.y * 32'(FB_WIDTH) + stage_q.x;
    assign push_entry.addr = fb_base_q + (pix_idx << 2);
    assign push_entry.data = color_q;
    assign q_push          = stage_valid_q && keep;

    assign mem_req_valid_o = !q_empty;
    assign mem_req_addr_o  = q_empty ? 32'd0 : head_entry.addr;
    assign mem_req_data_o  = q_empty ? 32'd0 : head_entry.data;
    assign xfer            = mem_req_valid_o && mem_req_ready_i;

    assign done_o = (state_q == StDone);

    frag_write_queue #(
        .LgDepth (LG_WQ_SZ),
        .Width   ($bits(wq_entry_t))
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (q_push),
        .push_data_i (push_entry),
        .pop_i       (xfer),
        .pop_data_o  (head_entry),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    always_comb begin
        state_d         = state_q;
        gen_done_seen_d = gen_done_seen_q;
        fb_base_d       = fb_base_q;
        color_d         = color_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    fb_base_d       = fb_base_i;
                    color_d         = color_i;
                    gen_done_seen_d = gen_done_i;
                    state_d         = StRun;
                end
            end
            StRun: begin
                if (gen_done_i) gen_done_seen_d = 1'b1;
                if (gen_done_seen_q && !frag_val_i && !stage_valid_q) state_d = StDrain;
            end
            StDrain: begin
                // Leave as the last entry transfers so done follows it by one cycle.
                if (q_empty || ((q_count == (LG_WQ_SZ + 1)'(1)) && xfer)) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            gen_done_seen_q <= 1'b0;
            fb_base_q       <= '0;
            color_q         <= '0;
            stage_q         <= '0;
            stage_valid_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            gen_done_seen_q <= gen_done_seen_d;
            fb_base_q       <= fb_base_d;
            color_q         <= color_d;
            stage_valid_q   <= pop_frag_o;
            if (pop_frag_o) stage_q <= frag_in;
        end
    end

`ifdef FRAG_WRITER_STATS_EN
    logic [31:0] stat_in_q, stat_culled_q, stat_written_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || start_acc) begin
            stat_in_q      <= '0;
            stat_culled_q  <= '0;
            stat_written_q <= '0;
        end else begin
            if (pop_frag_o)              stat_in_q      <= sat_inc(stat_in_q);
            if (stage_valid_q && !keep)  stat_culled_q  <= sat_inc(stat_culled_q);
            if (xfer)                    stat_written_q <= sat_inc(stat_written_q);
        end
    end

    assign stat_in_o      = stat_in_q;
    assign stat_culled_o  = stat_culled_q;
    assign stat_written_o = stat_written_q;
`else
    assign stat_in_o      = 32'd0;
    assign stat_culled_o  = 32'd0;
    assign stat_written_o = 32'd0;
`endif

endmodule

// File: tb/tb_frag_writer.sv
module tb_frag_writer;

    logic        clk = 1'b0;
    logic        rst, start, gen_done, frag_val, mem_req_ready;
    logic [31:0] fb_base, color, x_in, y_in, w0_in, w1_in, w2_in;
    logic        pop_frag, mem_req_valid, done;
    logic [31:0] mem_req_addr, mem_req_data, stat_in, stat_culled, stat_written;

    always #5 clk = ~clk;

    frag_writer u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .fb_base_i       (fb_base),
        .color_i         (color),
        .gen_done_i      (gen_done),
        .frag_val_i      (frag_val),
        .x_in_i          (x_in),
        .y_in_i          (y_in),
        .w0_in_i         (w0_in),
        .w1_in_i         (w1_in),
        .w2_in_i         (w2_in),
        .pop_frag_o      (pop_frag),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_data_o  (mem_req_data),
        .done_o          (done),
        .stat_in_o       (stat_in),
        .stat_culled_o   (stat_culled),
        .stat_written_o  (stat_written)
    );

    localparam logic [31:0] WPos = 32'h3F80_0000;

    int unsigned   cyc = 0;
    int            nchecks = 0;
    int            nerr = 0;
    int            n_pops = 0;
    int unsigned   last_xfer_cyc = 0;
    logic          pop_seen = 1'b0;
    logic [31:0]   cur_color;
    logic [159:0]  gen_q[$];
    logic [63:0]   exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Generator FIFO model: dequeue on a sampled pop, then present the new head.
    always @(posedge clk) begin
        #1;
        if (pop_seen && gen_q.size() > 0) gen_q.delete(0);
        #1;
        frag_val = (gen_q.size() != 0);
        if (gen_q.size() != 0) {x_in, y_in, w0_in, w1_in, w2_in} = gen_q[0];
    end

    // Scoreboard monitor: every transfer pops and checks one expected write.
    always @(negedge clk) begin
        logic [63:0] e;
        pop_seen = pop_frag;
        if (pop_frag) n_pops++;
        if (mem_req_valid && mem_req_ready) begin
            last_xfer_cyc = cyc;
            if (exp_q.size() == 0) begin
                nchecks++;
                nerr++;
                $display("FAIL unexpected_write: got addr 0x%08h required no write", mem_req_addr);
            end else begin
                e = exp_q[0];
                exp_q.delete(0);
                check("wr_addr", mem_req_addr, e[63:32]);
                check("wr_data", mem_req_data, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [31:0] col);
        fb_base   = base;
        color     = col;
        cur_color = col;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic push_frag(input logic [31:0] x, input logic [31:0] y, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2, input bit wr,
                             input logic [31:0] addr);
        gen_q.push_back({x, y, w0, w1, w2});
        if (wr) exp_q.push_back({addr, cur_color});
    endtask

    task automatic pulse_gen_done();
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
    endtask

    task automatic wait_done(input bit chk_lat);
        bit found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(found), 32'd1);
        if (chk_lat) check("done_latency", 32'(cyc - last_xfer_cyc), 32'd1);
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        tick();
    endtask

    task automatic check_stats(input logic [31:0] si, input logic [31:0] sc,
                               input logic [31:0] sw);
`ifdef FRAG_WRITER_STATS_EN
        check("stat_in", stat_in, si);
        check("stat_culled", stat_culled, sc);
        check("stat_written", stat_written, sw);
`else
        check("stat_in", stat_in, 32'd0 & si);
        check("stat_culled", stat_culled, 32'd0 & sc);
        check("stat_written", stat_written, 32'd0 & sw);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned p, v, first, last, cnt, p0;

        rst = 1'b1; start = 1'b0; gen_done = 1'b0; frag_val = 1'b0; mem_req_ready = 1'b0;
        fb_base = '0; color = '0; cur_color = '0;
        x_in = '0; y_in = '0; w0_in = '0; w1_in = '0; w2_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pop", 32'(pop_frag), 32'd0);
        check("rst_valid", 32'(mem_req_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", mem_req_addr, 32'd0);
        check("rst_data", mem_req_data, 32'd0);
        check_stats(32'd0, 32'd0, 32'd0);
        rst = 1'b0;
        tick();

        // Address, inside test and bounds.
        mem_req_ready = 1'b1;
        do_start(32'h1000_0000, 32'hAABB_CCDD);
        push_frag(3, 2, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 1'b1, 32'h1000_140C);
        p = 0; v = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pop_frag) begin p = cyc; break; end
        end
        for (int k = 0; k < 20; k++) begin
            if (mem_req_valid) begin v = cyc; break; end
            @(negedge clk);
        end
        check("first_write_latency", 32'(v - p), 32'd2);
        push_frag(4, 4, 32'hBF80_0000, WPos, WPos, 1'b0, 32'd0);
        push_frag(5, 1, 32'h8000_0000, WPos, WPos, 1'b1, 32'h1000_0A14);
        push_frag(640, 0, WPos, WPos, WPos, 1'b0, 32'd0);
        push_frag(0, 480, WPos, WPos, WPos, 1'b0, 32'd0);
        push_frag(639, 479, WPos, WPos, WPos, 1'b1, 32'h1012_BFFC);
        tick();
        pulse_gen_done();
        wait_done(1'b0);
        check_stats(32'd6, 32'd3, 32'd3);

        // Backpressure: only the queue depth is popped while ready is low.
        mem_req_ready = 1'b0;
        do_start(32'h2000_0000, 32'h1122_3344);
        p0 = n_pops;
        for (int i = 0; i < 10; i++)
            push_frag(32'(i), 0, WPos, WPos, WPos, 1'b1, 32'h2000_0000 + 32'(i * 4));
        repeat (20) tick();
        check("bp_pops", 32'(n_pops - p0), 32'd4);
        @(negedge clk);
        check("bp_pop_frag", 32'(pop_frag), 32'd0);
        check("bp_valid", 32'(mem_req_valid), 32'd1);
        check("bp_addr_a", mem_req_addr, 32'h2000_0000);
        repeat (5) @(negedge clk);
        check("bp_addr_b", mem_req_addr, 32'h2000_0000);
        check("bp_data_b", mem_req_data, 32'h1122_3344);
        tick();
        mem_req_ready = 1'b1;
        cnt = 0; first = 0; last = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                if (cnt == 0) first = cyc;
                cnt++;
                last = cyc;
            end
            if (cnt == 10) break;
        end
        check("bp_write_count", cnt, 32'd10);
        check("bp_no_bubbles", 32'(last - first), 32'd9);
        tick();
        pulse_gen_done();
        wait_done(1'b0);

        // Completion with pending writes; a start while running is ignored.
        mem_req_ready = 1'b0;
        do_start(32'h3000_0000, 32'hCAFE_F00D);
        fb_base = 32'h5555_0000;
        color   = 32'h0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        push_frag(1, 1, WPos, WPos, WPos, 1'b1, 32'h3000_0A04);
        push_frag(2, 1, WPos, WPos, WPos, 1'b1, 32'h3000_0A08);
        push_frag(3, 1, WPos, WPos, WPos, 1'b1, 32'h3000_0A0C);
        repeat (8) tick();
        pulse_gen_done();
        repeat (4) tick();
        check("no_early_done", 32'(done), 32'd0);
        mem_req_ready = 1'b1;
        wait_done(1'b1);

        // Reset with a full queue discards pending work.
        mem_req_ready = 1'b0;
        do_start(32'h4000_0000, 32'h0F0F_0F0F);
        for (int i = 0; i < 6; i++) push_frag(32'(i), 3, WPos, WPos, WPos, 1'b0, 32'd0);
        repeat (10) tick();
        check("pre_rst_valid", 32'(mem_req_valid), 32'd1);
        rst = 1'b1;
        gen_q.delete();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", 32'(mem_req_valid), 32'd0);
        check("mid_rst_pop", 32'(pop_frag), 32'd0);
        check_stats(32'd0, 32'd0, 32'd0);
        rst = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        do_start(32'h4000_0000, 32'h0F0F_0F0F);
        push_frag(10, 10, WPos, WPos, WPos, 1'b1, 32'h4000_6428);
        repeat (3) tick();
        pulse_gen_done();
        wait_done(1'b0);
        check_stats(32'd1, 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/frag_writer.md
Name: frag_writer

Overview:
- Downstream consumer of the fragment generator's FIFO.
- Pops fragments (x, y, w0, w1, w2) and keeps those inside the triangle (all three fp32 weights non-negative) and inside the framebuffer.
- Turns each kept fragment into a framebuffer word address and issues a 32-bit colour write on a valid/ready memory port.
- Pulses done once the generator has finished and all writes have drained.

Parameters:
- FB_WIDTH, 640, framebuffer width in pixels.
- FB_HEIGHT, 480, framebuffer height in pixels.
- LG_WQ_SZ, 2, log2 of the write-queue depth (depth 4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a triangle; sampled in IDLE only
- fb_base  in  32  framebuffer byte base address; latched on start
- color  in  32  RGBA written for covered pixels; latched on start
- gen_done  in  1  generator done pulse
- frag_val  in  1  generator FIFO non-empty
- x_in, y_in  in  32  unsigned fragment coordinates
- w0_in, w1_in, w2_in  in  32  fp32 barycentric weights
- pop_frag  out  1  dequeue the generator FIFO head this cycle
- mem_req_valid  out  1  write request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  32  byte address
- mem_req_data  out  32  write data
- done  out  1  one-cycle completion pulse
- stat_in, stat_culled, stat_written  out  32  statistics counters (see Optional Feature)

Behaviour:
- Reset values:
  - pop_frag=0, mem_req_valid=0, done=0.
  - mem_req_addr=0, mem_req_data=0, all stat_*=0.
  - State IDLE, queue pointers 0, stage valid 0, gen_done latch 0.
- States:
  - IDLE: on start, latch fb_base and color, clear the gen_done latch, go to RUN. Fragments are never popped in IDLE.
  - RUN: pop and process fragments. Latch gen_done whenever it is seen, including in the same cycle as start.
  - DRAIN: entered from RUN when the latch is set, frag_val=0 and the stage is empty. Stay until the queue is empty and no request is outstanding.
  - DONE: assert done for exactly one cycle, then return to IDLE.
- A start seen outside IDLE is ignored.
- pop_frag = (state==RUN) && frag_val && (queue occupancy + stage_valid < 2^LG_WQ_SZ). It is combinational and never depends on mem_req_ready in the same cycle.
- Stage 1: the fragment popped at edge t is held in the stage register during cycle t+1. The inside/bounds/address result is pushed at edge t+2, so mem_req_valid is high no earlier than cycle t+2.
- Inside test: w is non-negative when bit31==0 or w[30:0]==0, so -0.0 passes. NaN with sign bit 0 passes (not special-cased).
- Bounds: x<FB_WIDTH and y<FB_HEIGHT. Fragments failing the inside test or bounds are discarded and never reach the queue.
- Address: fb_base + ((y*FB_WIDTH + x) << 2), computed mod 2^32; wrap-around is not flagged. mem_req_data = latched color.
- Memory handshake:
  - A request transfers when mem_req_valid && mem_req_ready.
  - addr and data stay stable while valid && !ready.
  - The queue head pops on transfer. Push and pop in the same cycle are allowed when the queue is full.
- Queue: circular buffer with LG_WQ_SZ+1-bit pointers. full = low bits equal and MSBs differ; empty = pointers equal.
- Reset mid-operation: in-flight stage and queue contents are discarded without being written; the bench must not expect those writes.

Optional Feature:
- Macro: FRAG_WRITER_STATS_EN.
- Defined:
  - stat_in counts pops.
  - stat_culled counts fragments discarded by the inside or bounds test.
  - stat_written counts memory transfers.
  - All three clear on an accepted start and saturate at 0xFFFFFFFF.
  - Invariant at done: stat_in == stat_culled + stat_written.
- Undefined: the counters are not built and stat_* are tied to 0. The ports remain so the top level is unchanged.

Decomposition:
- rasterizer.vh holds fragment_t, the FB_WIDTH/FB_HEIGHT defaults, LG_WQ_SZ and the FSM state typedef.
- One sub-module, frag_write_queue: a parameterised push/pop FIFO of {addr, data} that exposes full, empty and an occupancy count.

Test Plan:
- Address generation:
  - Stimulus: fb_base=0x10000000, x=3, y=2, all w=0x3F000000, mem_req_ready=1.
  - Response: one write, addr 0x1000140C, data=color, first seen 2 cycles after the pop.
- Inside test:
  - Stimulus: w0=0xBF800000, w1=w2=0x3F800000.
  - Response: fragment popped, no write; stat_culled=1.
  - Stimulus: w0=0x80000000.
  - Response: written.
- Bounds:
  - Stimulus: x=640, y=0 and x=0, y=480.
  - Response: both dropped, no writes.
  - Stimulus: x=639, y=479.
  - Response: addr = fb_base + 0x12BFFC.
- Backpressure:
  - Stimulus: mem_req_ready=0 with 10 valid fragments queued.
  - Response: exactly 4 popped, then pop_frag=0 and addr/data stable.
  - Stimulus: release ready.
  - Response: 10 writes in order, 1 per cycle, with no bubbles once the queue is non-empty.
- Completion:
  - Stimulus: gen_done pulse while 3 writes are pending.
  - Response: done pulses one cycle after the last transfer, state returns to IDLE, and a start during RUN is ignored.
- Reset mid-operation:
  - Stimulus: rst asserted with the queue full.
  - Response: next cycle mem_req_valid=0, pop_frag=0, stat_*=0; a subsequent start works normally.
